// File: rtl/booth_div_seq.sv
// booth_div_seq: sequential signed restoring divider.
//
// Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor. The
// divider works on magnitudes and produces one quotient bit per clock. The
// quotient truncates toward zero, and the remainder takes the sign of the
// dividend. This block undoes results from the Booth multiplier.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous, active-high reset
//   start_i        request; sampled only in IDLE
//   dividend_i     signed dividend (2*WIDTH), captured on accepted start
//   divisor_i      signed divisor (WIDTH), captured on accepted start
//   busy_o         high while a division is in progress
//   done_o         one-cycle pulse when results become valid
//   quotient_o     signed quotient, truncated toward zero
//   remainder_o    signed remainder, sign follows dividend
//   overflow_o     true quotient does not fit WIDTH signed bits
//   div_by_zero_o  divisor was zero
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold the last result
// CALC  | 2*WIDTH shift/trial-subtract iterations on magnitudes
// FIX   | apply signs, range check, publish result, pulse done_o

module booth_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic               overflow_o,
    output logic               div_by_zero_o
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] LIM_POS = DW'((1 << (WIDTH - 1)) - 1);
    localparam logic [DW-1:0] LIM_NEG = DW'(1 << (WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    // dvd_q starts as the dividend magnitude. Quotient bits shift in at
    // the bottom, so it holds the quotient magnitude after 2*WIDTH steps.
    logic [DW-1:0]   dvd_q;
    // The divisor magnitude can reach 2^(WIDTH-1), so it needs WIDTH+1 bits.
    logic [WIDTH:0]  dsr_q;
    // The partial remainder stays below the divisor magnitude, so WIDTH bits
    // are enough.
    logic [WIDTH-1:0] rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            dz_q;

    logic [WIDTH:0]   shifted;
    logic             q_bit;
    logic [WIDTH-1:0] rem_d;
    logic [DW-1:0]    dvd_d;
    logic [DW-1:0]    dvd_mag_d;
    logic [WIDTH:0]   dsr_mag_d;
    logic             ovf_d;

    always_comb begin
        shifted   = {rem_q, dvd_q[DW-1]};
        q_bit     = (shifted >= dsr_q);
        rem_d     = q_bit ? WIDTH'(shifted - dsr_q) : WIDTH'(shifted);
        dvd_d     = {dvd_q[DW-2:0], q_bit};
        dvd_mag_d = dividend_i[DW-1] ? (DW'(0) - dividend_i) : dividend_i;
        dsr_mag_d = divisor_i[WIDTH-1] ? ((WIDTH + 1)'(0) - {1'b1, divisor_i})
                                       : {1'b0, divisor_i};
        // A negative result may reach one magnitude step further than a
        // positive result.
        ovf_d     = q_neg_q ? (dvd_q > LIM_NEG) : (dvd_q > LIM_POS);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            rem_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            overflow_o    <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        q_neg_q       <= dividend_i[DW-1] ^ divisor_i[WIDTH-1];
                        r_neg_q       <= dividend_i[DW-1];
                        dvd_q         <= dvd_mag_d;
                        dsr_q         <= dsr_mag_d;
                        rem_q         <= '0;
                        cnt_q         <= '0;
                        dz_q          <= (divisor_i == '0);
                        busy_o        <= 1'b1;
                        overflow_o    <= 1'b0;
                        div_by_zero_o <= 1'b0;
                        state_q       <= (divisor_i == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dz_q) begin
                        quotient_o    <= '0;
                        remainder_o   <= '0;
                        overflow_o    <= 1'b0;
                        div_by_zero_o <= 1'b1;
                    end else begin
                        quotient_o  <= q_neg_q ? WIDTH'(DW'(0) - dvd_q)
                                               : dvd_q[WIDTH-1:0];
                        remainder_o <= r_neg_q ? (WIDTH'(0) - rem_q) : rem_q;
                        overflow_o  <= ovf_d;
                    end
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_div_seq.md
Name: booth_div_seq

Overview:
- Sequential signed restoring divider; the inverse operation of the team's Booth multiplier.
- Takes a 2*WIDTH-bit signed product-sized dividend and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit signed quotient and remainder, one magnitude bit per clock, with a start/busy/done handshake.
- Used to check and undo multiplier results in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width; dividend is 2*WIDTH bits, quotient/remainder WIDTH bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  2*WIDTH  signed dividend, captured on accepted start
divisor  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign follows dividend (zero if exact)
overflow  output  1  true quotient not representable in WIDTH signed bits
div_by_zero  output  1  divisor was zero

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset, including mid-operation: state IDLE; busy, done, quotient, remainder, overflow, div_by_zero all 0; the in-flight operation is abandoned.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Capture sign flags.
  - Dividend magnitude: 2*WIDTH-bit unsigned, so -2^(2W-1) is representable.
  - Divisor magnitude: WIDTH+1 bits, so -2^(W-1) is representable.
  - Partial remainder and iteration counter cleared.
  - busy=1.
  - If divisor==0, go to FIX directly; otherwise go to CALC.
- CALC, edges E1..E2W (exactly 2*WIDTH iterations):
  - Shift the (remainder, dividend) pair left by 1.
  - Trial-subtract the divisor magnitude; keep the result if non-negative and shift in quotient bit 1, else restore and shift in 0.
  - After the 2*WIDTH-th iteration, go to FIX.
- FIX, one edge:
  - Negate the quotient magnitude if the operand signs differ.
  - Negate the remainder magnitude if the dividend is negative.
  - Register quotient and remainder as the low WIDTH bits.
  - overflow=1 if the magnitude exceeds 2^(W-1)-1 for a non-negative result, or 2^(W-1) for a negative result.
  - Set done=1, busy=0, next state IDLE.
- Latency: done is high in the cycle after edge E(2W+1), i.e. 2*WIDTH+1 clocks after the start edge (17 for WIDTH=8). Divide-by-zero gives done 1 clock after the start edge.
- Divide by zero: quotient=0, remainder=0, div_by_zero=1, overflow=0.
- Outputs and flags hold their values until the next accepted start, which clears done, overflow and div_by_zero.
- done is a single-cycle pulse.
- start while busy, or during the FIX cycle: ignored, no effect on the operation in flight.
- Back-to-back: a start in the cycle after done is accepted.
- Operands may change freely after the start edge; only captured values are used.
- Remainder magnitude is always below the divisor magnitude, so it always fits WIDTH signed bits.

Test Plan:
- WIDTH=8, dividend=9052, divisor=73, start 1 cycle -> busy for 17 cycles; done pulse exactly 17 clocks after the start edge; quotient=124, remainder=0, overflow=0.
- Signs:
  - -9052/73 -> -124 r0.
  - 9053/-73 -> -124 r1.
  - -9053/-73 -> 124 r-1.
  - -16384/-128 -> 128 overflows (overflow=1).
  - 16384/-128 -> -128, overflow=0.
- Overflow: 9052/1 -> overflow=1, done after 17 clocks; -128/1 -> quotient=-128, overflow=0; 127/1 -> 127, overflow=0.
- Divide by zero: 500/0 -> done 1 clock after start; div_by_zero=1, quotient=0, remainder=0.
- Handshake:
  - start re-asserted at cycles 3 and 17 of a run with operands 1000/7 -> ignored; result is from the first operands.
  - start in the cycle after done -> accepted.
- Reset mid-operation: assert reset at cycle 8 of 9052/73 -> next cycle all outputs 0, no done pulse; a new start of 100/-7 completes normally -> -14 r2.
